imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 clk  input  1  Single clock; all state updates on rising edge.
REQ-002 reset  input  1  Asynchronous, active-high reset.
REQ-003 in_valid  input  1  Upstream byte valid.
REQ-004 in_data  input  8  Upstream byte; transferred when in_valid & in_ready are high at a rising clk edge.
REQ-005 in_ready  output  1  Loader can accept a byte this cycle.
REQ-006 rd_addr  input  4  Core fetch address (pc).
REQ-007 rd_inst  output  8  Instruction at rd_addr; combinational read, no latency.
REQ-008 core_resetn  output  1  Active-low reset to core; low whenever state is not RUN.
REQ-009 done  output  1  High while in RUN (valid program loaded).
REQ-010 error  output  1  Sticky checksum-failure flag.
REQ-011 Parameter HDR, default 8'hA5, meaning frame header byte.

Function
REQ-012 Storage SHALL be 16 x 8-bit entries, written only by the loader; rd_inst SHALL reflect writes from the cycle after the write edge.
REQ-013 Frame SHALL be: HDR, then 16 instruction bytes for addresses 0..15 in order, then 1 checksum byte.
REQ-014 Checksum SHALL be the 8-bit modulo-256 sum of the 16 instruction bytes; carry out discarded.
REQ-015 States SHALL be WAIT_HDR, LOAD, CHECK, RUN.
REQ-016 WAIT_HDR: in_ready=1; accepted byte == HDR -> LOAD, wr_ptr=0, sum=0, error cleared; any other byte discarded, no state change.
REQ-017 LOAD: in_ready=1; each accepted byte written to entry wr_ptr, added into sum, wr_ptr incremented; the accept with wr_ptr==15 -> CHECK; wr_ptr SHALL NOT wrap into a 17th write.
REQ-018 LOAD SHALL treat a byte equal to HDR as data (no resync).
REQ-019 CHECK: in_ready=1; the accepted byte is compared with sum; equal -> RUN; unequal -> error=1 and WAIT_HDR.
REQ-020 RUN: in_ready=1; accepted byte == HDR -> LOAD (same initialisation as REQ-016), core_resetn low from the next cycle; other bytes discarded.
REQ-021 Cycles with in_valid=0 SHALL not change state, pointer, sum or memory; arbitrary gaps between bytes are allowed.
REQ-022 core_resetn and done SHALL be registered outputs derived from next state, so core_resetn rises on the same edge the state enters RUN.
REQ-023 After a failed frame, memory SHALL keep the partially/fully written bytes; core_resetn SHALL stay low until a frame passes.
REQ-024 An abandoned frame (upstream stops mid-LOAD) SHALL stall in LOAD indefinitely; only reset or completion exits.

Reset
REQ-025 On reset assertion, immediately and asynchronously: state=WAIT_HDR, wr_ptr=0, sum=0, all 16 entries=8'h00, core_resetn=0, done=0, error=0.
REQ-026 Reset asserted mid-LOAD or in RUN SHALL discard the frame in progress and clear memory; in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-027 Good frame: A5, bytes 01..10 (hex), checksum 88 -> done=1, core_resetn=1 after checksum edge; rd_addr=0..15 reads 01..10; error=0.
REQ-028 Bad checksum: A5, sixteen 00 bytes, checksum 01 -> error=1, done=0, core_resetn=0, state WAIT_HDR; following good frame clears error and reaches RUN.
REQ-029 Noise and gaps: bytes 00, FF, 3C before A5, then good frame with in_valid toggling every other cycle -> noise ignored, memory equals frame, done=1.
REQ-030 Reload from RUN: after good frame, send A5 -> core_resetn=0 and done=0 the next cycle; second frame 16 x 80, checksum 00 -> RUN with all entries 80.
REQ-031 Header as data/wrap: frame whose byte 5 is A5 and checksum correct -> entry 5 = A5, exactly 16 writes, RUN reached.
REQ-032 Reset mid-load: assert reset after 7 data bytes -> all outputs to REQ-025 values at once; all entries read 00; next full frame loads normally.

Source files
------------

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader with checksum gate
//
// Receives a framed program over a byte stream (header, 16 instruction bytes,
// modulo-256 checksum) into a 16 x 8 instruction store and holds the core in
// reset until a frame with a matching checksum has been loaded.
//
// Ports:
//   clk          - single clock, rising-edge
//   reset        - asynchronous active-high reset
//   in_valid     - upstream byte valid
//   in_data      - upstream byte, taken when in_valid & in_ready
//   in_ready     - loader accepts a byte this cycle
//   rd_addr      - core fetch address
//   rd_inst      - instruction at rd_addr (combinational read)
//   core_resetn  - active-low core reset, high only in RUN
//   done         - high while in RUN
//   error        - sticky checksum-failure flag, cleared by the next header
module imem_loader #(
    parameter logic [7:0] HDR = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_inst,
    output logic       core_resetn,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {
        WAIT_HDR = 2'd0,
        LOAD     = 2'd1,
        CHECK    = 2'd2,
        RUN      = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  wr_ptr_q, wr_ptr_d;
    logic [7:0]  sum_q, sum_d;
    logic        error_q, error_d;
    logic        done_q, done_d;
    logic        core_resetn_q, core_resetn_d;
    logic [7:0]  mem_q [16];
    logic [7:0]  mem_d [16];
    logic        accept;

    // Every state can take a byte; bytes that mean nothing in a state are dropped.
    assign in_ready = 1'b1;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        sum_d    = sum_q;
        error_d  = error_q;
        mem_d    = mem_q;

        case (state_q)
            WAIT_HDR, RUN: begin
                if (accept && in_data == HDR) begin
                    state_d  = LOAD;
                    wr_ptr_d = 4'd0;
                    sum_d    = 8'd0;
                    error_d  = 1'b0;
                end
            end
            LOAD: begin
                // A header-valued byte here is ordinary data; no resync.
                if (accept) begin
                    mem_d[wr_ptr_q] = in_data;
                    sum_d           = sum_q + in_data;
                    if (wr_ptr_q == 4'd15) begin
                        // Pointer is left at 15 so it can never wrap into a 17th write.
                        state_d = CHECK;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 4'd1;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (in_data == sum_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = WAIT_HDR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_HDR;
        endcase

        // Registered from next state so core_resetn rises on the edge RUN is entered.
        done_d        = (state_d == RUN);
        core_resetn_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_HDR;
            wr_ptr_q      <= 4'd0;
            sum_q         <= 8'd0;
            error_q       <= 1'b0;
            done_q        <= 1'b0;
            core_resetn_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            sum_q         <= sum_d;
            error_q       <= error_d;
            done_q        <= done_d;
            core_resetn_q <= core_resetn_d;
            for (int i = 0; i < 16; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_inst     = mem_q[rd_addr];
    assign core_resetn = core_resetn_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule
